// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-beat RAM port between two requesters.
// Each grant registers the address, write data and write enable to the RAM.
// Reads return through a two-stage {valid, port} pipeline, so read data reaches
// the winning requester three cycles after its request was sampled.
// Optional build macro: ARB_FIXED_PRIO_EN. When it is defined, port 0 always
// wins ties. When it is undefined, ties are resolved round-robin.
//
// Request/grant handshake:
//   A requester raises reqN and holds weN/addrN/wdataN stable until gntN is
//   seen. gntN is a one-cycle pulse meaning the access was issued to the RAM
//   in that cycle. A request that is sampled while its own gnt is high is
//   ignored. A requester may therefore present its next request in the gnt
//   cycle, and that request is taken no earlier than the following cycle.
//   Reads complete with a one-cycle rvalidN pulse; rdataN holds its value
//   between pulses. Writes produce no rvalid.

module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    // Grant and RAM command registers
    logic              r_gnt0;
    logic              r_gnt1;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_we;

    // Read return pipeline: stage 1 is the gnt cycle, stage 2 is the ram_out cycle
    logic              r_s1_valid;
    logic              r_s1_port;
    logic              r_s2_valid;
    logic              r_s2_port;

    // Read data outputs
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifndef ARB_FIXED_PRIO_EN
    // 1 = port 1 won the most recent grant, so port 0 wins the next tie
    logic              r_last;
`endif

    // Arbitration and winner-mux wires
    logic              w_eff0;
    logic              w_eff1;
    logic              w_win0;
    logic              w_win1;
    logic              w_win_any;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    // Effective requests, winner selection and mux of the winner's command
    always_comb begin
        w_eff0 = req0 & ~r_gnt0;
        w_eff1 = req1 & ~r_gnt1;
`ifdef ARB_FIXED_PRIO_EN
        w_win0 = w_eff0;
        w_win1 = w_eff1 & ~w_eff0;
`else
        w_win0 = w_eff0 & (~w_eff1 | r_last);
        w_win1 = w_eff1 & (~w_eff0 | ~r_last);
`endif
        w_win_any   = w_win0 | w_win1;
        w_we_sel    = w_win1 ? we1    : we0;
        w_addr_sel  = w_win1 ? addr1  : addr0;
        w_wdata_sel = w_win1 ? wdata1 : wdata0;
    end

    // Register the grants and the RAM command. Address and data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_we   <= 1'b0;
        end else begin
            r_gnt0 <= w_win0;
            r_gnt1 <= w_win1;
            if (w_win_any) begin
                r_ram_addr <= w_addr_sel;
                r_ram_data <= w_wdata_sel;
                r_ram_we   <= w_we_sel;
            end else begin
                r_ram_we   <= 1'b0;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer records the most recent winner; it changes only on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_win0) begin
            r_last <= 1'b0;
        end else if (w_win1) begin
            r_last <= 1'b1;
        end
    end
`endif

    // Advance the read tags: a read enters stage 1 with its grant and moves to stage 2 next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_port  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_port  <= 1'b0;
        end else begin
            r_s1_valid <= w_win_any & ~w_we_sel;
            r_s1_port  <= w_win1;
            r_s2_valid <= r_s1_valid;
            r_s2_port  <= r_s1_port;
        end
    end

    // Capture ram_out for the tagged port and pulse that port's rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= r_s2_valid & ~r_s2_port;
            r_rvalid1 <= r_s2_valid & r_s2_port;
            if (r_s2_valid && !r_s2_port) begin
                r_rdata0 <= ram_out;
            end
            if (r_s2_valid && r_s2_port) begin
                r_rdata1 <= ram_out;
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign ram_we   = r_ram_we;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = r_s1_valid | r_s2_valid;

endmodule
